pci_master: RTL and testbench

PCI_MASTER -- requirements
Module: pci_master

---
 rtl/pci_pkg.sv | 40 ++++
 rtl/pci_master.sv | 236 +++++++++++++++++++++++
 tb/tb_pci_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// pci_pkg: shared definitions for the PCI bus master.
//   - pci_state_e : bus-master FSM states
//   - CMD_*       : C/BE# command codes driven in the address phase
//   - RW_*        : request direction codes on the RW input
//   - STAT_*      : completion status codes reported with Done
//   - DEVSEL_TIMEOUT_DEF : default master-abort timeout in data-phase clocks
//   - req_valid() : qualifies a start request (direction and length)
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOPWAIT = 3'd3,
        ST_TURN     = 3'd4
    } pci_state_e;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] CBE_IDLE      = 4'b1111;
    localparam logic [3:0] CBE_ALL_BYTES = 4'b0000;

    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;

    localparam logic [1:0] STAT_OK           = 2'd0;
    localparam logic [1:0] STAT_DISCONNECT   = 2'd1;
    localparam logic [1:0] STAT_MASTER_ABORT = 2'd2;
    localparam logic [1:0] STAT_TARGET_ABORT = 2'd3;

    localparam int DEVSEL_TIMEOUT_DEF = 4;

    // A request starts a burst only for a read/write direction and a length of 1..max_len.
    function automatic logic req_valid(input logic [1:0] rw, input logic [3:0] len,
                                       input int max_len);
        return ((rw == RW_READ) || (rw == RW_WRITE)) && (len != 4'd0) &&
               (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/pci_master.sv
// pci_master: single-channel PCI burst master (memory read / memory write).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   Req, RW, Addr, Len         burst request (sampled in IDLE only)
//   WrData / WrPop             write-word source and its pop strobe
//   RdData / RdValid           last read word and its one-cycle valid pulse
//   Busy, Done, Status, Count  transaction progress and completion report
//   Frame, Iready, CBE         active-low FRAME#, IRDY#, C/BE#
//   AD_out, AD_oe, AD_in       multiplexed address/data bus
//   Devsel, Tready, Stop       active-low target responses DEVSEL#, TRDY#, STOP#
module pci_master
    import pci_pkg::*;
#(
    parameter int MAX_LEN        = 8,
    parameter int DEVSEL_TIMEOUT = DEVSEL_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic [1:0]  RW,
    input  logic [31:0] Addr,
    input  logic [3:0]  Len,
    input  logic [31:0] WrData,
    output logic        WrPop,
    output logic [31:0] RdData,
    output logic        RdValid,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  Status,
    output logic [3:0]  Count,
    output logic        Frame,
    output logic        Iready,
    output logic [3:0]  CBE,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    input  logic        Devsel,
    input  logic        Tready,
    input  logic        Stop,
    input  logic [31:0] AD_in
);

    localparam logic [7:0] DEVSEL_LAST = 8'(DEVSEL_TIMEOUT - 1);

    pci_state_e  r_state;
    pci_state_e  w_state_nxt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [3:0]  r_len;
    logic [3:0]  r_rem;
    logic [3:0]  w_rem_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic [3:0]  w_count_inc;
    logic [7:0]  r_dcnt;
    logic [7:0]  w_dcnt_nxt;
    logic        r_seen;
    logic        w_seen_nxt;
    logic [1:0]  r_status;
    logic [1:0]  w_status_nxt;
    logic [31:0] r_rddata;
    logic        r_rdvalid;
    logic        w_start;
    logic        w_xfer;

    assign w_start = (r_state == ST_IDLE) && Req && req_valid(RW, Len, MAX_LEN);
    // IRDY# is always asserted in DATA, so a word moves whenever the target is selected and ready.
    assign w_xfer      = (r_state == ST_DATA) && !Devsel && !Tready;
    assign w_count_inc = r_count + {3'b000, w_xfer};

    // Next-state and counter update logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_count_nxt  = r_count;
        w_dcnt_nxt   = r_dcnt;
        w_seen_nxt   = r_seen;
        w_status_nxt = r_status;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_ADDR;
                    w_rem_nxt    = Len;
                    w_count_nxt  = 4'd0;
                    w_dcnt_nxt   = 8'd0;
                    w_seen_nxt   = 1'b0;
                    w_status_nxt = STAT_OK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (!Devsel) begin
                    w_seen_nxt = 1'b1;
                    w_dcnt_nxt = 8'd0;
                end else begin
                    w_seen_nxt = r_seen;
                end
                if (w_xfer) begin
                    w_count_nxt = w_count_inc;
                    w_rem_nxt   = r_rem - 4'd1;
                end else begin
                    w_count_nxt = r_count;
                end
                if (!Stop && !Devsel) begin
                    // Disconnect: a word moving on this edge still counts toward Count.
                    w_state_nxt  = ST_STOPWAIT;
                    w_status_nxt = (w_count_inc == r_len) ? STAT_OK : STAT_DISCONNECT;
                end else if (!Stop && Devsel && r_seen) begin
                    w_state_nxt  = ST_STOPWAIT;
                    w_status_nxt = STAT_TARGET_ABORT;
                end else if (w_xfer && (r_rem == 4'd1)) begin
                    w_state_nxt  = ST_TURN;
                    w_status_nxt = STAT_OK;
                end else if (Devsel && !r_seen) begin
                    // No target has claimed the cycle yet: run the master-abort timer.
                    if (r_dcnt == DEVSEL_LAST) begin
                        w_state_nxt  = ST_TURN;
                        w_status_nxt = STAT_MASTER_ABORT;
                        w_count_nxt  = 4'd0;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOPWAIT: begin
                if (Stop) begin
                    w_state_nxt = ST_TURN;
                end else begin
                    w_state_nxt = ST_STOPWAIT;
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, latched request and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= 32'd0;
            r_write   <= 1'b0;
            r_len     <= 4'd0;
            r_rem     <= 4'd0;
            r_count   <= 4'd0;
            r_dcnt    <= 8'd0;
            r_seen    <= 1'b0;
            r_status  <= STAT_OK;
            r_rddata  <= 32'd0;
            r_rdvalid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_count   <= w_count_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_seen    <= w_seen_nxt;
            r_status  <= w_status_nxt;
            r_rdvalid <= w_xfer && !r_write;
            if (w_start) begin
                r_addr  <= Addr;
                r_write <= (RW == RW_WRITE);
                r_len   <= Len;
            end
            if (w_xfer && !r_write) begin
                r_rddata <= AD_in;
            end
        end
    end

    // Bus and handshake outputs decoded from the current state.
    always_comb begin
        Frame  = 1'b1;
        Iready = 1'b1;
        CBE    = CBE_IDLE;
        AD_out = 32'd0;
        AD_oe  = 1'b0;
        WrPop  = 1'b0;
        Done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Frame = 1'b1;
            end
            ST_ADDR: begin
                Frame  = 1'b0;
                AD_out = r_addr;
                AD_oe  = 1'b1;
                CBE    = r_write ? CMD_MEM_WRITE : CMD_MEM_READ;
            end
            ST_DATA: begin
                // FRAME# is released while the last word is outstanding.
                Frame  = (r_rem == 4'd1);
                Iready = 1'b0;
                CBE    = CBE_ALL_BYTES;
                if (r_write) begin
                    AD_oe  = 1'b1;
                    AD_out = WrData;
                    WrPop  = w_xfer;
                end else begin
                    AD_oe = 1'b0;
                end
            end
            ST_STOPWAIT: begin
                Iready = 1'b0;
                CBE    = CBE_ALL_BYTES;
                if (r_write) begin
                    AD_oe  = 1'b1;
                    AD_out = WrData;
                end else begin
                    AD_oe = 1'b0;
                end
            end
            ST_TURN: begin
                Done = 1'b1;
            end
            default: begin
                Frame = 1'b1;
            end
        endcase
    end

    assign Busy    = (r_state != ST_IDLE);
    assign Status  = r_status;
    assign Count   = r_count;
    assign RdData  = r_rddata;
    assign RdValid = r_rdvalid;

endmodule

// File: tb/tb_pci_master.sv
// tb_pci_master: randomized bench for pci_master with a transaction-level
// reference model of the target handshake and the expected completion report.
module tb_pci_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Req = 1'b0;
    logic [1:0]  RW = 2'd0;
    logic [31:0] Addr = 32'd0;
    logic [3:0]  Len = 4'd0;
    logic [31:0] WrData = 32'd0;
    logic        WrPop;
    logic [31:0] RdData;
    logic        RdValid;
    logic        Busy;
    logic        Done;
    logic [1:0]  Status;
    logic [3:0]  Count;
    logic        Frame;
    logic        Iready;
    logic [3:0]  CBE;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic        Devsel = 1'b1;
    logic        Tready = 1'b1;
    logic        Stop = 1'b1;
    logic [31:0] AD_in = 32'd0;

    int n_vec = 0;
    int n_err = 0;

    pci_master #(.MAX_LEN(8), .DEVSEL_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .Req(Req), .RW(RW), .Addr(Addr), .Len(Len),
        .WrData(WrData), .WrPop(WrPop), .RdData(RdData), .RdValid(RdValid),
        .Busy(Busy), .Done(Done), .Status(Status), .Count(Count),
        .Frame(Frame), .Iready(Iready), .CBE(CBE), .AD_out(AD_out), .AD_oe(AD_oe),
        .Devsel(Devsel), .Tready(Tready), .Stop(Stop), .AD_in(AD_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        Req    = 1'b0;
        Devsel = 1'b1;
        Tready = 1'b1;
        Stop   = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},   {31'd0, Busy},    32'd0);
        check({tag, ".frame"},  {31'd0, Frame},   32'd1);
        check({tag, ".irdy"},   {31'd0, Iready},  32'd1);
        check({tag, ".cbe"},    {28'd0, CBE},     32'hF);
        check({tag, ".adoe"},   {31'd0, AD_oe},   32'd0);
        check({tag, ".adout"},  AD_out,           32'd0);
        check({tag, ".rddata"}, RdData,           32'd0);
        check({tag, ".count"},  {28'd0, Count},   32'd0);
        check({tag, ".status"}, {30'd0, Status},  32'd0);
        check({tag, ".rdvalid"},{31'd0, RdValid}, 32'd0);
        check({tag, ".wrpop"},  {31'd0, WrPop},   32'd0);
        check({tag, ".done"},   {31'd0, Done},    32'd0);
    endtask

    // One burst against a scripted target. dd: data cycle where DEVSEL# asserts (-1 never).
    // smode: 0 none, 1 disconnect, 2 target abort, at data cycle sc; STOP# held shold extra cycles.
    // Starts and ends 2 time units after a rising edge with the master idle.
    task automatic run_txn(input logic [1:0] rw, input logic [31:0] addr, input int len,
                           input int dd, input int smode, input int sc, input int shold,
                           input int tdelay, input int tprob);
        logic [31:0] words [16];
        logic        wr;
        bit          valid;
        int          c, done, miss, phase, k, exp_status;
        bit          seen, dev_on, st, xfer, rd_pending;
        logic [31:0] rd_exp;
        wr    = (rw == 2'd2);
        valid = (rw == 2'd1 || rw == 2'd2) && len >= 1 && len <= 8;
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        Req = 1'b1; RW = rw; Addr = addr; Len = 4'(len); WrData = words[0];
        @(posedge clk); #1;
        // Scramble the request inputs: the burst must run on the latched values.
        Req = 1'b0; RW = 2'($urandom); Addr = $urandom; Len = 4'($urandom);
        #1;
        if (!valid) begin
            for (int i = 0; i < 2; i++) begin
                check("ign.busy",  {31'd0, Busy},  32'd0);
                check("ign.frame", {31'd0, Frame}, 32'd1);
                check("ign.adoe",  {31'd0, AD_oe}, 32'd0);
                @(posedge clk); #2;
            end
            return;
        end
        check("addr.busy",  {31'd0, Busy},   32'd1);
        check("addr.frame", {31'd0, Frame},  32'd0);
        check("addr.irdy",  {31'd0, Iready}, 32'd1);
        check("addr.ad",    AD_out,          addr);
        check("addr.adoe",  {31'd0, AD_oe},  32'd1);
        check("addr.cbe",   {28'd0, CBE},    wr ? 32'h7 : 32'h6);
        c = 0; done = 0; miss = 0; phase = 0; seen = 0; rd_pending = 0; rd_exp = 32'd0;
        exp_status = 0;
        while (phase == 0) begin
            @(posedge clk); #1;
            dev_on = (dd >= 0) && (c >= dd);
            st     = (smode != 0) && (c == sc);
            if (smode == 2 && st) dev_on = 1'b0;
            Devsel = !dev_on;
            Stop   = !st;
            Tready = (c > 20) ? 1'b0 : ((c < tdelay) ? 1'b1 : ($urandom_range(99) >= tprob));
            AD_in  = $urandom;
            WrData = words[done];
            #1;
            check("data.rdvalid", {31'd0, RdValid}, {31'd0, rd_pending});
            if (rd_pending) check("data.rddata", RdData, rd_exp);
            check("data.irdy",  {31'd0, Iready}, 32'd0);
            check("data.frame", {31'd0, Frame},  {31'd0, (len - done) == 1});
            check("data.cbe",   {28'd0, CBE},    32'h0);
            check("data.adoe",  {31'd0, AD_oe},  {31'd0, wr});
            check("data.done",  {31'd0, Done},   32'd0);
            if (wr) check("data.ad", AD_out, words[done]);
            xfer = dev_on && !Tready;
            check("data.wrpop", {31'd0, WrPop}, {31'd0, wr && xfer});
            rd_pending = !wr && xfer;
            rd_exp     = AD_in;
            if (st && dev_on) begin
                done = done + int'(xfer);
                exp_status = (done == len) ? 0 : 1;
                phase = 1;
            end else if (st && !dev_on && seen) begin
                exp_status = 3;
                phase = 1;
            end else if (xfer) begin
                done++;
                if (done == len) begin
                    exp_status = 0;
                    phase = 2;
                end
            end else if (!dev_on && !seen) begin
                miss++;
                if (miss == TO) begin
                    exp_status = 2;
                    done = 0;
                    phase = 2;
                end
            end
            if (dev_on) begin
                seen = 1;
                miss = 0;
            end
            c++;
            if (phase == 0 && c > 60) begin
                check("data.timeout", 32'd1, 32'd0);
                phase = 2;
            end
        end
        k = 0;
        while (phase == 1) begin
            @(posedge clk); #1;
            Stop   = (k >= shold);
            Devsel = (smode == 2);
            Tready = 1'b0;
            #1;
            check("sw.rdvalid", {31'd0, RdValid}, {31'd0, rd_pending});
            if (rd_pending) check("sw.rddata", RdData, rd_exp);
            rd_pending = 0;
            check("sw.frame", {31'd0, Frame},  32'd1);
            check("sw.irdy",  {31'd0, Iready}, 32'd0);
            check("sw.wrpop", {31'd0, WrPop},  32'd0);
            check("sw.done",  {31'd0, Done},   32'd0);
            if (Stop) phase = 2;
            k++;
        end
        @(posedge clk); #1;
        bus_idle();
        #1;
        check("turn.done",   {31'd0, Done},   32'd1);
        check("turn.status", {30'd0, Status}, 32'(exp_status));
        check("turn.count",  {28'd0, Count},  32'(done));
        check("turn.frame",  {31'd0, Frame},  32'd1);
        check("turn.irdy",   {31'd0, Iready}, 32'd1);
        check("turn.cbe",    {28'd0, CBE},    32'hF);
        check("turn.adoe",   {31'd0, AD_oe},  32'd0);
        check("turn.rdvalid",{31'd0, RdValid},{31'd0, rd_pending});
        if (rd_pending) check("turn.rddata", RdData, rd_exp);
        @(posedge clk); #2;
        check("post.busy", {31'd0, Busy}, 32'd0);
        check("post.done", {31'd0, Done}, 32'd0);
    endtask

    // Reset in the middle of a Len=8 read: everything returns to idle and no Done follows.
    task automatic reset_mid_burst();
        Req = 1'b1; RW = 2'd1; Addr = 32'hABCD_0000; Len = 4'd8;
        @(posedge clk); #1;
        Req = 1'b0;
        @(posedge clk); #1;
        Devsel = 1'b0; Tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_idle();
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("midrst.nodone", {31'd0, Done}, 32'd0);
            check("midrst.busy",   {31'd0, Busy}, 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  rw;
        logic [31:0] a;
        int          len, dd, smode, sc;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");
        // Write Len=3, target claims at once and is always ready.
        run_txn(2'd2, 32'h0000_1000, 3, 0, 0, 0, 0, 0, 100);
        // Read Len=1, TRDY# delayed two cycles.
        run_txn(2'd1, 32'h0000_2000, 1, 0, 0, 0, 0, 2, 100);
        // Read Len=4, nobody claims: master abort.
        run_txn(2'd1, 32'h0000_3000, 4, -1, 0, 0, 0, 0, 100);
        // Write Len=4, disconnect with data on the 2nd word, STOP# held 2 extra cycles.
        run_txn(2'd2, 32'h0000_4000, 4, 0, 1, 1, 2, 0, 100);
        // Read Len=6, target abort after DEVSEL# was seen.
        run_txn(2'd1, 32'h0000_5000, 6, 0, 2, 2, 1, 0, 50);
        // Disconnect exactly on the final word reports OK.
        run_txn(2'd1, 32'h0000_6000, 2, 1, 1, 2, 0, 0, 100);
        // Max length write, late DEVSEL# just inside the timeout.
        run_txn(2'd2, 32'h0000_7000, 8, 3, 0, 0, 0, 0, 70);
        // Requests that must be ignored.
        run_txn(2'd0, 32'h0000_8000, 2, 0, 0, 0, 0, 0, 100);
        run_txn(2'd3, 32'h0000_8000, 2, 0, 0, 0, 0, 0, 100);
        run_txn(2'd1, 32'h0000_8000, 0, 0, 0, 0, 0, 0, 100);
        run_txn(2'd2, 32'h0000_8000, 9, 0, 0, 0, 0, 0, 100);
        reset_mid_burst();
        run_txn(2'd1, 32'h0000_9000, 1, 0, 0, 0, 0, 0, 100);
        for (int t = 0; t < 60; t++) begin
            rw  = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? 2'd0 : 2'd3)
                                           : 2'($urandom_range(2, 1));
            len = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? 0 : int'($urandom_range(15, 9)))
                                           : int'($urandom_range(8, 1));
            dd  = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(3, 0));
            smode = ($urandom_range(3) < 2) ? 0 : int'($urandom_range(2, 1));
            sc  = ((dd < 0) ? 0 : dd) + 1 + int'($urandom_range(3, 0));
            a   = $urandom;
            run_txn(rw, a, len, dd, smode, sc, int'($urandom_range(2, 0)),
                    int'($urandom_range(1, 0)), 60);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
